// File: rtl/sseg_pkg.sv
// Character codes and active-low seven-segment patterns (bit order g..a).
// Pure constants and a helper; no latency, no backpressure.
package sseg_pkg;

  localparam int CHAR_W = 5;

  localparam logic [CHAR_W-1:0] CH_BLANK = 5'd16;
  localparam logic [CHAR_W-1:0] CH_DASH  = 5'd17;
  localparam logic [CHAR_W-1:0] CH_H     = 5'd18;
  localparam logic [CHAR_W-1:0] CH_L     = 5'd19;
  localparam logic [CHAR_W-1:0] CH_P     = 5'd20;
  localparam logic [CHAR_W-1:0] CH_U     = 5'd21;
  localparam logic [CHAR_W-1:0] CH_R     = 5'd22;
  localparam logic [CHAR_W-1:0] CH_N     = 5'd23;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_N     = 7'h2B;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/sseg_char_decoder.sv
// Combinational 5-bit character code to active-low segments; codes 24-31 are blank.
// Zero latency, no backpressure.
module sseg_char_decoder
  import sseg_pkg::*;
(
  input  logic [CHAR_W-1:0] code,
  output logic [6:0]        seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!code[4]) begin
      seg = hex_seg(code[3:0]);
    end else begin
      case (code)
        CH_DASH: seg = SEG_DASH;
        CH_H:    seg = SEG_H;
        CH_L:    seg = SEG_L;
        CH_P:    seg = SEG_P;
        CH_U:    seg = SEG_U;
        CH_R:    seg = SEG_R;
        CH_N:    seg = SEG_N;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sseg_banner_scroller.sv
// Scrolling banner on a multiplexed common-anode display; step_clk is only a synchronized scroll event.
// an/seg registered one cycle after digit/offset; step lands on offset two edges after capture; no backpressure.
module sseg_banner_scroller
  import sseg_pkg::*;
#(
  parameter int MSG_LEN     = 16,
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step_clk,
  input  logic                       en,
  input  logic                       dir,
  input  logic [CHAR_W*MSG_LEN-1:0]  msg,
  output logic [N_DIGITS-1:0]        an,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [$clog2(MSG_LEN)-1:0] offset
);

  localparam int OW = $clog2(MSG_LEN);
  localparam int IW = OW + 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic              sync0, sync1, sync1_d;
  logic [1:0]        fill;
  logic              armed;
  logic              step;
  logic [RW-1:0]     rcnt;
  logic              rcnt_tc;
  logic [DW-1:0]     digit;
  logic [IW-1:0]     idx_sum;
  logic [OW-1:0]     ch_idx;
  logic [CHAR_W-1:0] ch_code;
  logic [6:0]        seg_next;
  logic [N_DIGITS-1:0] an_next;

  assign step    = armed & sync1 & ~sync1_d;
  assign rcnt_tc = (rcnt == RW'(REFRESH_DIV - 1));
  assign dp      = 1'b1;

  // fill marks when sync1 holds a real sample rather than its reset zero,
  // so a step_clk already high at reset release cannot arm the detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      sync1_d <= 1'b0;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sync0   <= step_clk;
      sync1   <= sync0;
      sync1_d <= sync1;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && !sync1) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset <= '0;
    end else if (step && en) begin
      if (dir) offset <= (offset == '0) ? OW'(MSG_LEN - 1) : offset - OW'(1);
      else     offset <= (offset == OW'(MSG_LEN - 1)) ? '0 : offset + OW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt  <= '0;
      digit <= '0;
    end else if (rcnt_tc) begin
      rcnt  <= '0;
      digit <= (digit == DW'(N_DIGITS - 1)) ? '0 : digit + DW'(1);
    end else begin
      rcnt  <= rcnt + RW'(1);
    end
  end

  // Sum is below 2*MSG_LEN, so one conditional subtract completes the modulo.
  assign idx_sum = {1'b0, offset} + IW'(digit);
  assign ch_idx  = (idx_sum >= IW'(MSG_LEN)) ? OW'(idx_sum - IW'(MSG_LEN)) : idx_sum[OW-1:0];

  always_comb begin
    ch_code = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (ch_idx == OW'(i)) ch_code = msg[CHAR_W*i +: CHAR_W];
    end
  end

  always_comb begin
    an_next = '1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (digit == DW'(d)) an_next[N_DIGITS-1-d] = 1'b0;
    end
  end

  sseg_char_decoder u_dec (
    .code (ch_code),
    .seg  (seg_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= 7'h7F;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: doc/sseg_banner_scroller.md
# sseg_banner_scroller

Consumes the 1 Hz divided clock from the clock divider and drives a multiplexed common-anode seven-segment display so that a fixed-length character message scrolls one position per slow-clock rising edge. It sits between the divider and the board's anode/segment pins. It contains its own refresh counter for digit multiplexing, so the divider output is used only as a scroll-step event and never as a clock.

## Interface
- `MSG_LEN`, 16: characters in the message; legal range `N_DIGITS..32`.
- `N_DIGITS`, 4: physical digits.
- `REFRESH_DIV`, 100000: `clk` cycles each digit stays lit (1 kHz per digit at 100 MHz); must be at least 2.
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: asynchronous, active-high reset.
- `step_clk` in 1: divided clock level from the divider; asynchronous to the logic here and synchronized internally.
- `en` in 1: scroll enable; display refresh continues when low.
- `dir` in 1: 0 = scroll left (offset +1), 1 = scroll right (offset −1).
- `msg` in `5*MSG_LEN`: character codes; char i is `msg[5i+4:5i]`.
- `an` out `N_DIGITS`: active-low anodes; bit `N_DIGITS-1` is the leftmost digit.
- `seg` out 7: active-low segments, bit order g..a.
- `dp` out 1: active-low decimal point; always 1.
- `offset` out `$clog2(MSG_LEN)`: current scroll position.

## Operation
- **Step detection.** `step_clk` passes through a 2-flop synchronizer, then a rising-edge detector, producing the one-cycle `step` pulse.
- **Arming.** An `armed` flag clears on reset and sets once the synchronized `step_clk` is seen low. `step` is suppressed while `armed`=0, so a `step_clk` that is already high at reset release never causes a scroll.
- **Scrolling.** On `step` with `en`=1:
  - `dir`=0: `offset` ← (`offset`+1) mod `MSG_LEN`, so `MSG_LEN-1` wraps to 0.
  - `dir`=1: `offset` ← (`offset`−1) mod `MSG_LEN`, so 0 wraps to `MSG_LEN-1`.
  - With `en`=0, `offset` holds and the step is discarded, not queued.
  - A change on `dir` takes effect at the next step.
- **Refresh.**
  - `rcnt` counts 0..`REFRESH_DIV`-1 and wraps.
  - At terminal count, `digit` advances 0..`N_DIGITS`-1 and wraps.
  - `digit`=d lights the anode for position d, where d=0 is the leftmost, i.e. `an` bit `N_DIGITS-1-d`.
- **Character selection.** Position d shows character index (`offset`+d) mod `MSG_LEN`. The modulo is computed with a wider adder and a single conditional subtract; no divider is used.
- **Character codes.** 0–15 are hex 0–F; 16 is blank; 17 is '-'; 18 'H'; 19 'L'; 20 'P'; 21 'U'; 22 'r'; 23 'n'. Codes 24–31 display blank.
- **Simultaneous step and refresh terminal.** Both take effect on the same edge. The newly selected digit uses the new `offset`.
- **Mid-operation reset.** All state clears immediately, asynchronously, regardless of refresh phase or pending step.
- **`msg` changes.** Changes on `msg` appear at the next output register update, with no resynchronization.

## Timing
- Reset values:
  - `an` = all 1s and `seg` = 7'h7F, so the display is blank.
  - `dp` = 1, `offset` = 0.
  - `rcnt`, `digit`, `armed` and the synchronizer flops = 0.
- `an` and `seg` are registered and update together on the same edge, with 1-cycle latency from `digit`/`offset`.
- First lit output: `an` = 4'b0111 (for `N_DIGITS`=4) appears on the first `clk` edge after reset deasserts.
- Step latency: `step_clk` rising captured at edge k → `step` high in the cycle after edge k+1 → `offset` updates at edge k+2 → `seg` reflects it at edge k+3 if that digit is selected.
- Each digit is lit for exactly `REFRESH_DIV` cycles; a full scan takes `N_DIGITS*REFRESH_DIV` cycles.
- Exactly one `an` bit is low at any time after the first post-reset edge.

## Structure
- Package `sseg_pkg`:
  - Character-code localparams (`CH_BLANK`=16 … `CH_N`=23).
  - 7-bit active-low segment pattern constants.
  - `CHAR_W`=5.
- Sub-module `sseg_char_decoder`: combinational, 5-bit code → 7-bit active-low segments.
- Top-level contents: synchronizer/edge/arm logic, offset counter, refresh counter, digit counter, index adder, and output registers.

## Test plan
All scenarios use `REFRESH_DIV`=4, `N_DIGITS`=4, `MSG_LEN`=8.
- **Reset and scan.** Assert `reset` → `an`=4'hF, `seg`=7'h7F, `offset`=0. Release → `an` walks 0111, 1011, 1101, 1110 with 4 cycles each.
- **Left scroll with wrap.** Use `msg` = chars 0..7. Apply 8 `step_clk` pulses with `en`=1, `dir`=0 → `offset` runs 1..7 then 0. At `offset`=6 the digits show 6,7,0,1.
- **Right scroll wrap.** `dir`=1, single step from `offset`=0 → `offset`=7, and the leftmost digit shows '7'.
- **Enable hold.** `en`=0 with 3 `step_clk` pulses → `offset` unchanged, scan continues. Set `en`=1 and apply one pulse → `offset`+1 only.
- **Arming.** Hold `step_clk`=1 through reset release → no offset change. Drop `step_clk` to 0, then raise it → `offset` increments exactly once.
- **Mid-scan reset, then step/terminal coincidence.**
  - Assert `reset` while `digit`=2 and `step` is pending → all outputs return to reset values and no increment occurs afterwards.
  - Align `step` with `rcnt`=3 → the next digit displays using the new `offset`.
